// File: rtl/icache_refill.sv
// icache_refill: memory-side line refill engine for the instruction cache.
// Reads one line as 64-bit beats, fills the data array, then writes the tag.
module icache_refill #(
  parameter int LINE_BEATS = 4,
  parameter int IDX_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss,
  input  logic [31:0]      miss_addr,
  output logic             stall,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [63:0]      mem_rdata,
  output logic             fill,
  output logic [IDX_W-1:0] fill_idx,
  output logic [63:0]      stream,
  output logic             tag_we,
  output logic [2:0]       tag_idx,
  output logic [23:0]      tag_val,
  output logic [CNT_W-1:0] refill_cnt
);

  localparam int BW = $clog2(LINE_BEATS);
  localparam int LW = IDX_W - BW;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BEAT,
    TAG,
    SETTLE
  } state_t;

  state_t        state;
  logic [26:0]   line;
  logic [BW-1:0] beat;
  logic          unused_ok;

  assign unused_ok = ^miss_addr[4:0];

  // line holds addr[31:5]; every address output is derived from it
  assign mem_addr = {line, 5'b0};
  assign tag_idx  = line[2:0];
  assign tag_val  = line[26:3];
  assign stall    = miss | (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      line       <= '0;
      beat       <= '0;
      mem_req    <= 1'b0;
      fill       <= 1'b0;
      fill_idx   <= '0;
      stream     <= '0;
      tag_we     <= 1'b0;
      refill_cnt <= '0;
    end else begin
      fill   <= 1'b0;
      tag_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (miss) begin
            line    <= miss_addr[31:5];
            mem_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            beat    <= '0;
            state   <= BEAT;
          end
        end
        BEAT: begin
          if (mem_rvalid) begin
            fill     <= 1'b1;
            stream   <= mem_rdata;
            fill_idx <= {line[LW-1:0], beat};
            beat     <= beat + 1'b1;
            // last fill and tag write share a cycle
            if (beat == '1) begin
              tag_we <= 1'b1;
              state  <= TAG;
            end
          end
        end
        TAG: begin
          if (refill_cnt != '1)
            refill_cnt <= refill_cnt + 1'b1;
          state <= SETTLE;
        end
        SETTLE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: vector table for a basic refill plus
// hand-written sequences for the multi-cycle corner cases.
module tb_icache_refill;

  logic        clk;
  logic        rst_n;
  logic        miss;
  logic [31:0] miss_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        stall, mem_req, fill, tag_we;
  logic [31:0] mem_addr;
  logic [4:0]  fill_idx;
  logic [63:0] stream;
  logic [2:0]  tag_idx;
  logic [23:0] tag_val;
  logic [15:0] refill_cnt;

  logic        stall_b, mem_req_b, fill_b, tag_we_b;
  logic [31:0] mem_addr_b;
  logic [4:0]  fill_idx_b;
  logic [63:0] stream_b;
  logic [2:0]  tag_idx_b;
  logic [23:0] tag_val_b;
  logic [1:0]  refill_cnt_b;

  int tests;
  int fails;
  int exp_cnt;

  icache_refill dut (
    .clk(clk), .rst_n(rst_n), .miss(miss), .miss_addr(miss_addr),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill(fill), .fill_idx(fill_idx), .stream(stream),
    .tag_we(tag_we), .tag_idx(tag_idx), .tag_val(tag_val),
    .refill_cnt(refill_cnt)
  );

  icache_refill #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .miss(miss), .miss_addr(miss_addr),
    .stall(stall_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill(fill_b), .fill_idx(fill_idx_b), .stream(stream_b),
    .tag_we(tag_we_b), .tag_idx(tag_idx_b), .tag_val(tag_val_b),
    .refill_cnt(refill_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_n;
    logic        miss;
    logic [31:0] addr;
    logic        gnt;
    logic        rv;
    logic [63:0] data;
    logic        stall;
    logic        req;
    logic [31:0] maddr;
    logic        fill;
    logic [4:0]  idx;
    logic [63:0] strm;
    logic        twe;
    logic [2:0]  tidx;
    logic [23:0] tval;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt();
    chk("cnt", refill_cnt, exp_cnt);
    chk("cnt_sat", refill_cnt_b, (exp_cnt > 3) ? 3 : exp_cnt);
  endtask

  // IDLE miss cycle (optional), then REQ cycles with gnt after gdly
  task automatic start(input logic [31:0] a, input int gdly,
                       input bit skip_idle);
    miss_addr = a;
    miss = 1'b1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!skip_idle) begin
      @(negedge clk);
      chk("idle_stall", stall, 1);
      chk("idle_req", mem_req, 0);
      nxt();
    end
    for (int g = 0; g <= gdly; g++) begin
      mem_gnt = (g == gdly);
      mem_rvalid = 1'b1;
      mem_rdata = 64'hDEAD_0000 + 64'(g);
      @(negedge clk);
      chk("req", mem_req, 1);
      chk("req_addr", mem_addr, {a[31:5], 5'b0});
      chk("req_fill", fill, 0);
      chk("req_stall", stall, 1);
      nxt();
    end
    mem_gnt = 1'b0;
  endtask

  // four back-to-back beats, then TAG, SETTLE and one IDLE cycle
  task automatic run_beats(input logic [63:0] d0, input logic [4:0] i0,
                           input logic [2:0] ti, input logic [23:0] tv,
                           input bit keep);
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = d0 + 64'(k);
      if (k == 4 && !keep) miss = 1'b0;
      @(negedge clk);
      chk("b_stall", stall, 1);
      chk("b_fill", fill, k > 0);
      if (k > 0) begin
        chk("b_idx", fill_idx, i0 + 5'(k - 1));
        chk("b_stream", stream, d0 + 64'(k - 1));
      end
      chk("b_tag_we", tag_we, k == 4);
      if (k == 4) begin
        chk("b_tag_idx", tag_idx, ti);
        chk("b_tag_val", tag_val, tv);
      end
      nxt();
    end
    mem_rvalid = 1'b1;
    @(negedge clk);
    chk("settle_fill", fill, 0);
    chk("settle_tag", tag_we, 0);
    chk("settle_stall", stall, 1);
    exp_cnt++;
    chk_cnt();
    nxt();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("post_fill", fill, 0);
    chk("post_stall", stall, keep);
    chk("post_req", mem_req, 0);
    nxt();
  endtask

  logic pat[8];
  int   nfill;
  int   nacc;

  initial begin
    tests = 0;
    fails = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    miss = 1'b1;
    miss_addr = 32'h0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 64'h0;

    //        rst miss addr          gnt rv data      stall req maddr
    //        fill idx strm  twe tidx tval cnt
    tbl[0]  = '{1, 1, 32'h0000_1234, 0, 0, 64'h0,    1, 0, 32'h0,
                0, 0, 64'h0,  0, 0, 24'h0, 0};
    tbl[1]  = '{1, 1, 32'h0000_1234, 0, 0, 64'h0,    1, 1, 32'h0000_1220,
                0, 0, 64'h0,  0, 0, 24'h0, 0};
    tbl[2]  = '{1, 1, 32'h0000_1234, 0, 1, 64'hDEAD, 1, 1, 32'h0000_1220,
                0, 0, 64'h0,  0, 0, 24'h0, 0};
    tbl[3]  = '{1, 1, 32'h0000_1234, 1, 0, 64'h0,    1, 1, 32'h0000_1220,
                0, 0, 64'h0,  0, 0, 24'h0, 0};
    tbl[4]  = '{1, 1, 32'h0000_1234, 0, 1, 64'hA0,   1, 0, 32'h0,
                0, 0, 64'h0,  0, 0, 24'h0, 0};
    tbl[5]  = '{1, 1, 32'h0000_1234, 0, 1, 64'hA1,   1, 0, 32'h0,
                1, 4, 64'hA0, 0, 0, 24'h0, 0};
    tbl[6]  = '{1, 1, 32'h0000_1234, 0, 1, 64'hA2,   1, 0, 32'h0,
                1, 5, 64'hA1, 0, 0, 24'h0, 0};
    tbl[7]  = '{1, 1, 32'h0000_1234, 0, 1, 64'hA3,   1, 0, 32'h0,
                1, 6, 64'hA2, 0, 0, 24'h0, 0};
    tbl[8]  = '{1, 0, 32'h0000_1234, 0, 0, 64'h0,    1, 0, 32'h0,
                1, 7, 64'hA3, 1, 1, 24'h000012, 0};
    tbl[9]  = '{1, 0, 32'h0000_1234, 0, 0, 64'h0,    1, 0, 32'h0,
                0, 0, 64'h0,  0, 0, 24'h0, 1};
    tbl[10] = '{1, 0, 32'h0000_1234, 0, 0, 64'h0,    0, 0, 32'h0,
                0, 0, 64'h0,  0, 0, 24'h0, 1};
    tbl[11] = '{1, 0, 32'h0000_1234, 0, 0, 64'h0,    0, 0, 32'h0,
                0, 0, 64'h0,  0, 0, 24'h0, 1};

    repeat (2) nxt();
    @(negedge clk);
    chk("rst_stall", stall, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fill", fill, 0);
    chk("rst_idx", fill_idx, 0);
    chk("rst_stream", stream, 0);
    chk("rst_tag_we", tag_we, 0);
    chk("rst_tag_idx", tag_idx, 0);
    chk("rst_tag_val", tag_val, 0);
    chk("rst_cnt", refill_cnt, 0);
    miss = 1'b0;
    #1;
    chk("rst_stall_lo", stall, 0);
    nxt();

    // basic refill
    for (int i = 0; i < 12; i++) begin
      rst_n = tbl[i].rst_n;
      miss = tbl[i].miss;
      miss_addr = tbl[i].addr;
      mem_gnt = tbl[i].gnt;
      mem_rvalid = tbl[i].rv;
      mem_rdata = tbl[i].data;
      @(negedge clk);
      chk("v_stall", stall, tbl[i].stall);
      chk("v_req", mem_req, tbl[i].req);
      if (tbl[i].req) chk("v_maddr", mem_addr, tbl[i].maddr);
      chk("v_fill", fill, tbl[i].fill);
      if (tbl[i].fill) begin
        chk("v_idx", fill_idx, tbl[i].idx);
        chk("v_stream", stream, tbl[i].strm);
      end
      chk("v_tag_we", tag_we, tbl[i].twe);
      if (tbl[i].twe) begin
        chk("v_tag_idx", tag_idx, tbl[i].tidx);
        chk("v_tag_val", tag_val, tbl[i].tval);
      end
      chk("v_cnt", refill_cnt, tbl[i].cnt);
      nxt();
    end
    exp_cnt = 1;

    // gapped beats: line 0x40 -> fill_idx 8..11
    pat = '{1, 0, 0, 1, 1, 0, 1, 0};
    start(32'h0000_0040, 0, 0);
    nfill = 0;
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      mem_rvalid = pat[k];
      mem_rdata = 64'hB0 + 64'(k);
      if (k == 7) miss = 1'b0;
      @(negedge clk);
      chk("g_stall", stall, 1);
      chk("g_fill", fill, (k > 0) && pat[(k > 0) ? k - 1 : 0]);
      if (fill) nfill++;
      if (k > 0 && pat[k - 1]) begin
        chk("g_idx", fill_idx, 5'd8 + 5'(nacc));
        chk("g_stream", stream, 64'hB0 + 64'(k - 1));
        nacc++;
      end
      chk("g_tag_we", tag_we, k == 7);
      nxt();
    end
    mem_rvalid = 1'b0;
    chk("g_nfill", 64'(nfill), 4);
    @(negedge clk);
    exp_cnt++;
    chk_cnt();
    chk("g_settle_stall", stall, 1);
    nxt();
    @(negedge clk);
    chk("g_idle_stall", stall, 0);
    nxt();

    // request held for 10 cycles, spurious rvalid ignored
    start(32'h0000_2468, 10, 0);
    run_beats(64'hC0, 5'd12, 3'd3, 24'h000024, 0);

    // reset after two beats
    start(32'h0000_0300, 0, 0);
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 64'hD0 + 64'(k);
      if (k == 2) begin
        rst_n = 1'b0;
        miss = 1'b0;
      end
      @(negedge clk);
      chk("r_fill", fill, k > 0);
      if (k > 0) chk("r_idx", fill_idx, 5'(k - 1));
      chk("r_tag_we", tag_we, 0);
      nxt();
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("r_post_fill", fill, 0);
      chk("r_post_req", mem_req, 0);
      chk("r_post_tag", tag_we, 0);
      chk("r_post_stall", stall, 0);
      chk_cnt();
      nxt();
    end
    mem_rvalid = 1'b0;
    start(32'h0000_00E0, 0, 0);
    run_beats(64'hE0, 5'd28, 3'd7, 24'h0, 0);

    // miss_addr changes while beats arrive
    start(32'h5A5A_5A40, 2, 0);
    miss_addr = 32'hFFFF_FF00;
    run_beats(64'hF0, 5'd8, 3'd2, 24'h5A5A5A, 0);

    // back-to-back: miss stays high through SETTLE
    start(32'h0000_1000, 0, 0);
    miss_addr = 32'h0000_2000;
    run_beats(64'h100, 5'd0, 3'd0, 24'h000010, 1);
    start(32'h0000_2000, 0, 1);
    run_beats(64'h200, 5'd0, 3'd0, 24'h000020, 0);

    // fifth refill since reset: narrow counter sticks at 3
    start(32'h0000_0080, 0, 0);
    run_beats(64'h300, 5'd16, 3'd4, 24'h0, 0);
    chk("final_cnt", refill_cnt, 5);
    chk("final_cnt_sat", refill_cnt_b, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Memory-side refill engine for the instruction cache.
- Watches the fetch stage `miss` flag and reads the missing 32-byte line from memory as 64-bit beats.
- Drives the icache fill port (`fill`, `fill_idx`, `stream`), then writes the line tag.
- Holds fetch (`pc_write` low via `stall`) until the line is resident.

Parameters:
- LINE_BEATS, 4, 64-bit beats per cache line; must be a power of two; fill_idx = {line index, beat number}.
- IDX_W, 5, width of the icache entry index (32 entries x 64 bits).
- CNT_W, 16, width of the saturating refill counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- miss  in  1  icache tag miss for the current PC.
- miss_addr  in  32  current PC, sampled when a refill is accepted.
- stall  out  1  high while a refill is pending or in progress; fetch must not advance.
- mem_req  out  1  line read request.
- mem_addr  out  32  line-aligned address: miss_addr with bits [4:0] = 0.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  64  read beat data.
- fill  out  1  icache write strobe.
- fill_idx  out  IDX_W  icache entry index.
- stream  out  64  icache write data.
- tag_we  out  1  tag write strobe.
- tag_idx  out  3  line index: miss_addr[7:5].
- tag_val  out  24  tag: miss_addr[31:8].
- refill_cnt  out  CNT_W  completed refills; saturates at all-ones.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state -> IDLE.
  - mem_req, fill, tag_we -> 0.
  - mem_addr, fill_idx, stream, tag_idx, tag_val, refill_cnt -> 0.
  - stall = miss (combinational).
  - Reset mid-refill aborts the refill; any later beats are ignored until a new request is granted.
- stall = miss OR (state != IDLE). It is combinational, so a miss stalls fetch in the same cycle it appears.
- IDLE:
  - If miss = 1: latch line address (miss_addr & ~32'h1F) into an internal register, drive mem_req = 1 and mem_addr from it next cycle, go to REQ.
  - mem_rvalid is ignored in IDLE.
- REQ:
  - mem_req stays high and mem_addr stays stable until mem_gnt = 1.
  - On the gnt cycle: mem_req drops the next cycle, beat counter -> 0, go to BEAT.
  - mem_rvalid is ignored in REQ, including in the gnt cycle.
- BEAT:
  - Each cycle with mem_rvalid = 1 produces, on the next cycle:
    - fill = 1,
    - stream = mem_rdata,
    - fill_idx = {line_addr[7:5], beat[1:0]}.
  - The beat counter then increments. Latency is one cycle from rvalid to fill. Gaps in rvalid are allowed; fill is 0 in gap cycles.
  - After the LINE_BEATS-th beat is accepted, go to TAG. The fill for the last beat and the tag write occur in the same cycle.
- TAG:
  - tag_we = 1 for exactly one cycle with tag_idx and tag_val from the latched address.
  - refill_cnt increments, saturating.
  - Go to SETTLE.
- SETTLE:
  - One cycle with no outputs active, so the tag array updates miss.
  - Go to IDLE.
  - miss is re-evaluated in IDLE. If miss is still high (the PC moved to another missing line), a new refill starts.
- Beats are written linearly from beat 0; there is no critical-word-first.
- Once a refill starts, the latched address is the one used, even if miss or miss_addr change mid-refill.
- Beats arriving in TAG or SETTLE are a protocol violation and are ignored (not written).
- fill_idx wraps within the line: the beat counter is log2(LINE_BEATS) bits.

Test Plan:
- Basic refill:
  - Stimulus: rst_n 0 for 2 cycles, then miss = 1, miss_addr = 32'h0000_1234, mem_gnt after 3 cycles, 4 back-to-back beats of 64'hA0..A3.
  - Required: mem_addr = 32'h0000_1220; fill pulses with fill_idx 4,5,6,7 and stream A0..A3; tag_we once with tag_idx = 1, tag_val = 24'h000012; refill_cnt = 1; stall low in the cycle after SETTLE once miss drops.
- Gapped beats:
  - Stimulus: rvalid pattern 1,0,0,1,1,0,1.
  - Required: exactly 4 fill pulses, each one cycle after its rvalid; no fill in gap cycles; stall high throughout.
- Request hold:
  - Stimulus: mem_gnt held low for 10 cycles.
  - Required: mem_req high and mem_addr constant for all 10 cycles; a spurious rvalid during REQ produces no fill.
- Reset mid-refill:
  - Stimulus: assert rst_n = 0 after 2 beats.
  - Required: next cycle fill = 0, mem_req = 0, tag_we never pulses, refill_cnt = 0.
  - Then: a new miss at 32'h0000_00E0 gives fill_idx 28..31.
- Address change mid-refill:
  - Stimulus: miss_addr changes to 32'hFFFF_FF00 during BEAT.
  - Required: fill_idx and tag_val still derive from the original latched address.
- Back-to-back misses and saturation:
  - Stimulus: miss held high through SETTLE.
  - Required: a new mem_req is issued the cycle after IDLE is re-entered.
  - With CNT_W = 2 forced: after 5 refills, refill_cnt = 3.
